// File: rtl/pulse_sync_monitor_pkg.sv
`default_nettype none
//==============================================================================
// Module      : pulse_sync_monitor_pkg
// Description : Shared types and constants for the pulse_sync_monitor block.
//               state_t    - monitor FSM state encoding
//               ERR_CNT_W  - width of the optional error statistics counter
// Revision    : 1.0 - initial release
//==============================================================================
package pulse_sync_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HUNT   = 2'b01,
        ST_VERIFY = 2'b10,
        ST_LOCKED = 2'b11
    } state_t;

    localparam int ERR_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/pulse_sync_monitor_edge.sv
`default_nettype none
//==============================================================================
// Module      : pulse_edge_detect
// Description : Rising-edge detector for the incoming strobe. A strobe held
//               high for several cycles produces a single event.
// Ports       : clk      - clock
//               reset    - asynchronous active-high reset
//               i_pulse  - strobe input, synchronous to clk
//               o_event  - high in the cycle of a 0->1 transition of i_pulse
// Revision    : 1.0 - initial release
//==============================================================================
module pulse_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_pulse,
    output logic o_event
);

    logic r_pulse_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pulse_d <= 1'b0;
        end else begin
            r_pulse_d <= i_pulse;
        end
    end

    assign o_event = i_pulse & ~r_pulse_d;

endmodule
`default_nettype wire

// File: rtl/pulse_sync_monitor.sv
`default_nettype none
//==============================================================================
// Module      : pulse_sync_monitor
// Description : Receive-side checker for a periodic single-bit strobe. Learns
//               the strobe period, locks after LOCK_COUNT consistent
//               intervals, then predicts each strobe and flags early or
//               missing ones. Drops lock after MISS_LIMIT consecutive errors.
// Parameters  : CNT_W      - interval counter width (periods 2..2^CNT_W-1)
//               LOCK_COUNT - matching intervals needed to lock (>=1)
//               MISS_LIMIT - consecutive errors that drop lock (>=1)
// Ports       : clk        - clock
//               reset      - asynchronous active-high reset
//               pulse_in   - strobe input, each rising edge is one event
//               locked     - high while in LOCKED
//               period     - learned / candidate period in cycles
//               predict    - high in the cycle a strobe edge is expected
//               err_pulse  - one-cycle pulse per early or missed strobe
//               err_count  - saturating error count (optional, see below)
// Options     : PULSE_SYNC_MONITOR_STATS_EN - when defined, adds err_count
// Revision    : 1.0 - initial release
//==============================================================================
module pulse_sync_monitor
    import pulse_sync_monitor_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 3,
    parameter int MISS_LIMIT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pulse_in,
    output logic                 locked,
    output logic [CNT_W-1:0]     period,
    output logic                 predict,
    output logic                 err_pulse
`ifdef PULSE_SYNC_MONITOR_STATS_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int c_MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int c_MISS_W  = $clog2(MISS_LIMIT + 1);

    localparam logic [CNT_W-1:0]     c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [c_MATCH_W-1:0] c_MATCH_ONE = c_MATCH_W'(1);
    localparam logic [c_MATCH_W-1:0] c_LOCK_M    = c_MATCH_W'(LOCK_COUNT);
    localparam logic [c_MISS_W-1:0]  c_MISS_M    = c_MISS_W'(MISS_LIMIT);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       w_period_nxt;
    logic [c_MATCH_W-1:0]   r_match;
    logic [c_MATCH_W-1:0]   w_match_nxt;
    logic [c_MATCH_W-1:0]   w_match_inc;
    logic [c_MISS_W-1:0]    r_miss;
    logic [c_MISS_W-1:0]    w_miss_nxt;
    logic [c_MISS_W-1:0]    w_miss_inc;
    logic                   r_err_pulse;
    logic                   w_err;

    logic                   w_event;
    logic                   w_cnt_max;
    logic                   w_expect;
    logic [CNT_W-1:0]       w_interval;

    pulse_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .i_pulse (pulse_in),
        .o_event (w_event)
    );

    // A saturated counter means the interval overflowed and is not trusted.
    assign w_cnt_max   = (r_cnt == c_CNT_MAX);
    assign w_interval  = r_cnt + 1'b1;
    assign w_expect    = (r_cnt == (r_period - 1'b1));
    assign w_match_inc = r_match + 1'b1;
    assign w_miss_inc  = r_miss + 1'b1;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and datapath decisions
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_period;
        w_match_nxt  = r_match;
        w_miss_nxt   = r_miss;
        w_err        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    w_state_nxt = ST_HUNT;
                end
            end

            ST_HUNT: begin
                if (w_event && !w_cnt_max) begin
                    w_period_nxt = w_interval;
                    w_match_nxt  = c_MATCH_ONE;
                    if (LOCK_COUNT == 1) begin
                        w_state_nxt = ST_LOCKED;
                        w_miss_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_VERIFY;
                    end
                end
            end

            ST_VERIFY: begin
                if (w_event) begin
                    if (w_cnt_max) begin
                        w_state_nxt = ST_HUNT;
                    end else if (w_interval == r_period) begin
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == c_LOCK_M) begin
                            w_state_nxt = ST_LOCKED;
                            w_miss_nxt  = '0;
                        end
                    end else begin
                        // Candidate changed: restart the run on the new value.
                        w_period_nxt = w_interval;
                        w_match_nxt  = c_MATCH_ONE;
                    end
                end else if (w_cnt_max) begin
                    w_state_nxt = ST_HUNT;
                end
            end

            ST_LOCKED: begin
                if (w_event && w_expect) begin
                    w_miss_nxt = '0;
                end else if (w_event || w_expect) begin
                    // Early edge (event) or missing edge (expected point, no event).
                    w_err      = 1'b1;
                    w_miss_nxt = w_miss_inc;
                    if (w_miss_inc == c_MISS_M) begin
                        // An early edge is kept as the first event of a new hunt.
                        w_state_nxt = w_event ? ST_HUNT : ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter restarts on every event, and on the expected point while locked
    // so the flywheel keeps running through a missing strobe.
    always_comb begin
        if (w_event) begin
            w_cnt_nxt = '0;
        end else if ((r_state == ST_LOCKED) && w_expect) begin
            w_cnt_nxt = '0;
        end else if (!w_cnt_max) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_period    <= '0;
            r_match     <= '0;
            r_miss      <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_period    <= w_period_nxt;
            r_match     <= w_match_nxt;
            r_miss      <= w_miss_nxt;
            r_err_pulse <= w_err;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs: decoded from registers only, no pulse_in path
    //--------------------------------------------------------------------------
    always_comb begin
        locked  = (r_state == ST_LOCKED);
        predict = (r_state == ST_LOCKED) && w_expect;
    end

    assign period    = r_period;
    assign err_pulse = r_err_pulse;

`ifdef PULSE_SYNC_MONITOR_STATS_EN
    // Advances on the same edge that raises err_pulse, so the new count is
    // visible in the cycle err_pulse is high.
    logic [ERR_CNT_W-1:0] r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_sync_monitor.sv
`default_nettype none
//==============================================================================
// Module      : tb_pulse_sync_monitor
// Description : Self-checking bench for pulse_sync_monitor. A timestamp-based
//               reference model tracks edge times and the expected strobe
//               time; directed and random strobe trains are compared against
//               it every cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pulse_sync_monitor;

    localparam int CNT_W      = 8;
    localparam int LOCK_COUNT = 3;
    localparam int MISS_LIMIT = 2;
    localparam int MAXV       = (1 << CNT_W) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_HUNT   = 1;
    localparam int M_VERIFY = 2;
    localparam int M_LOCKED = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             pulse_in = 1'b0;
    logic             locked;
    logic [CNT_W-1:0] period;
    logic             predict;
    logic             err_pulse;
`ifdef PULSE_SYNC_MONITOR_STATS_EN
    logic [15:0]      err_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    int t = 0;

    // Reference model state (timestamp based)
    int m_mode;
    int m_anchor;      // cycle of the last event or flywheel restart
    int m_per;
    int m_match;
    int m_miss;
    bit m_err;
    bit m_prev;
    int m_errcnt;

    pulse_sync_monitor #(
        .CNT_W      (CNT_W),
        .LOCK_COUNT (LOCK_COUNT),
        .MISS_LIMIT (MISS_LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pulse_in  (pulse_in),
        .locked    (locked),
        .period    (period),
        .predict   (predict),
        .err_pulse (err_pulse)
`ifdef PULSE_SYNC_MONITOR_STATS_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, got, exp);
        end
    endtask

    task automatic model_update(input bit p);
        bit ev;
        int interval;
        bit valid;
        bit due;
        ev       = p && !m_prev;
        m_prev   = p;
        interval = t - m_anchor;
        valid    = (interval <= MAXV);
        m_err    = 1'b0;
        if (m_mode == M_IDLE) begin
            if (ev) m_mode = M_HUNT;
        end else if (m_mode == M_HUNT) begin
            if (ev && valid) begin
                m_per   = interval;
                m_match = 1;
                if (LOCK_COUNT == 1) begin
                    m_mode = M_LOCKED;
                    m_miss = 0;
                end else begin
                    m_mode = M_VERIFY;
                end
            end
        end else if (m_mode == M_VERIFY) begin
            if (ev) begin
                if (!valid) begin
                    m_mode = M_HUNT;
                end else if (interval == m_per) begin
                    m_match++;
                    if (m_match == LOCK_COUNT) begin
                        m_mode = M_LOCKED;
                        m_miss = 0;
                    end
                end else begin
                    m_per   = interval;
                    m_match = 1;
                end
            end else if (interval - 1 >= MAXV) begin
                m_mode = M_HUNT;
            end
        end else begin
            due = (interval == m_per);
            if (ev && due) begin
                m_miss = 0;
            end else if (ev || due) begin
                m_err = 1'b1;
                m_miss++;
                if (m_errcnt < 65535) m_errcnt++;
                if (!ev) m_anchor = t;
                if (m_miss == MISS_LIMIT) m_mode = ev ? M_HUNT : M_IDLE;
            end
        end
        if (ev) m_anchor = t;
    endtask

    // One clock cycle with pulse_in = p; outputs checked mid-cycle.
    task automatic tick(input bit p);
        bit e_locked;
        pulse_in = p;
        @(negedge clk);
        e_locked = (m_mode == M_LOCKED);
        check("locked", locked, e_locked);
        check("period", period, m_per);
        check("predict", predict, e_locked && ((t - m_anchor) == m_per));
        check("err_pulse", err_pulse, m_err);
`ifdef PULSE_SYNC_MONITOR_STATS_EN
        check("err_count", err_count, m_errcnt);
`endif
        model_update(p);
        t++;
        @(posedge clk);
        #1;
    endtask

    // g cycles starting with a w-cycle-high strobe (or all low if absent).
    task automatic emit(input int g, input int w, input bit present);
        for (int i = 0; i < g; i++) begin
            tick(present && (i < w));
        end
    endtask

    task automatic train(input int per, input int n, input int w);
        for (int k = 0; k < n; k++) begin
            emit(per, w, 1'b1);
        end
    endtask

    // Called at posedge+1; asserts reset off the clock edge.
    task automatic apply_reset();
        #2;
        pulse_in = 1'b0;
        reset    = 1'b1;
        #1;
        check("rst_locked", locked, 0);
        check("rst_predict", predict, 0);
        check("rst_period", period, 0);
        check("rst_err_pulse", err_pulse, 0);
`ifdef PULSE_SYNC_MONITOR_STATS_EN
        check("rst_err_count", err_count, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        m_mode   = M_IDLE;
        m_per    = 0;
        m_match  = 0;
        m_miss   = 0;
        m_err    = 1'b0;
        m_prev   = 1'b0;
        m_anchor = t - 1;
        m_errcnt = 0;
    endtask

    initial begin
        int per;
        int n;
        int r;
        int w;

        @(posedge clk);
        #1;
        apply_reset();

        // Period 4, edges at cycles 2, 6, 10, ...
        tick(1'b0);
        tick(1'b0);
        train(4, 6, 1);
        check("lock_p4", locked, 1);
        check("period_p4", period, 4);

        // One omitted strobe, then on-time strobes
        emit(4, 1, 1'b0);
        train(4, 3, 1);
        check("lock_after_one_miss", locked, 1);

        // Two consecutive omitted strobes drop to IDLE, period held
        emit(4, 1, 1'b0);
        emit(4, 1, 1'b0);
        repeat (4) tick(1'b0);
        check("unlock_two_miss", locked, 0);
        check("period_held", period, 4);

        // Intervals 4, 4, 5, 5, 5 while verifying
        emit(4, 1, 1'b1);
        emit(4, 1, 1'b1);
        train(5, 4, 1);
        train(5, 3, 2);
        check("lock_p5", locked, 1);
        check("period_p5", period, 5);

        // Asynchronous reset while locked
        apply_reset();

        // Period 6 with 3-cycle-wide strobes
        tick(1'b0);
        train(6, 6, 3);
        check("lock_p6_wide", locked, 1);
        check("period_p6_wide", period, 6);

        // Drop lock, then an overflowing interval during verify and hunt
        repeat (20) tick(1'b0);
        emit(4, 1, 1'b1);
        emit(300, 1, 1'b1);
        train(7, 5, 1);
        check("lock_p7", locked, 1);

        // Early strobes: one tolerated, two consecutive drop to hunt
        emit(7, 1, 1'b1);
        emit(3, 1, 1'b1);
        train(7, 3, 1);
        emit(3, 1, 1'b1);
        emit(3, 1, 1'b1);
        train(7, 6, 1);
        check("relock_p7", locked, 1);

        // Random strobe trains with occasional omissions and early edges
        for (int s = 0; s < 25; s++) begin
            per = $urandom_range(2, 12);
            n   = $urandom_range(4, 10);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 9);
                w = $urandom_range(1, per - 1);
                if (r == 0) begin
                    emit(per, 1, 1'b0);
                end else if (r == 1 && per > 2) begin
                    emit($urandom_range(2, per - 1), 1, 1'b1);
                end else begin
                    emit(per, w, 1'b1);
                end
            end
        end

        // Reset again and confirm a clean restart
        apply_reset();
        tick(1'b0);
        train(9, 6, 4);
        check("lock_p9_after_reset", locked, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_sync_monitor.md
# pulse_sync_monitor

Receive-side checker for the periodic single-bit strobe produced by the team's free-running FSM counters. It watches `pulse_in`, learns the strobe period and locks after a run of consistent intervals. Once locked it predicts each upcoming strobe and flags early or missing strobes. It sits in the consuming clock domain and gives downstream logic a `locked` qualifier and a phase-aligned `predict` strobe.

## Interface
- `CNT_W`, default 8: interval counter width. Valid periods are 2 to 2^CNT_W−1.
- `LOCK_COUNT`, default 3: consecutive matching intervals required to lock. Must be ≥1.
- `MISS_LIMIT`, default 2: consecutive errors while locked that drop lock. Must be ≥1.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `pulse_in`, in, 1: strobe, synchronous to `clk`. Each rising edge is one event.
- `locked`, out, 1: high while the FSM is in LOCKED.
- `period`, out, CNT_W: learned or candidate period in cycles.
- `predict`, out, 1: high in the cycle a strobe edge is expected (LOCKED only).
- `err_pulse`, out, 1: one-cycle pulse per early or missed strobe.

## Operation
- Edge detect: `pulse_d` is a register (reset 0). `event = pulse_in & ~pulse_d`.
- Interval counter `cnt`, CNT_W bits, reset 0:
  - Increments every cycle and saturates at `MAX` = 2^CNT_W−1.
  - On event: `interval = cnt+1` and `cnt` is set to 0.
  - An event with `cnt == MAX` gives an invalid interval.
- Registers: `period_r` (reset 0), `match_cnt`, `miss_cnt` (reset 0).
- IDLE: on event, go to HUNT with `cnt` = 0.
- HUNT:
  - On an event with a valid interval: set `period_r` = interval, `match_cnt` = 1, go to VERIFY. If LOCK_COUNT == 1, go directly to LOCKED.
  - On an event with an invalid interval: stay in HUNT.
- VERIFY:
  - Event with interval == `period_r`: `match_cnt`++. When `match_cnt` reaches LOCK_COUNT, go to LOCKED and set `miss_cnt` = 0.
  - Event with a mismatching valid interval: set `period_r` = interval, `match_cnt` = 1, stay in VERIFY.
  - Invalid interval, or `cnt` reaching MAX: go to HUNT.
- LOCKED, expected point is `cnt == period_r−1`:
  - Event at the expected point: good strobe. `miss_cnt` = 0.
  - Event before the expected point (early): error. `cnt` = 0, which re-phases to the early edge.
  - No event at the expected point (miss): error. `cnt` = 0, and the flywheel continues as if the strobe had occurred.
  - Every error raises `err_pulse` and increments `miss_cnt`.
  - When `miss_cnt` reaches MISS_LIMIT:
    - After an early error, go to HUNT. The early edge serves as the first event.
    - After a miss, go to IDLE.
    - In both cases `period_r` is held.
- `predict = (state == LOCKED) && (cnt == period_r−1)`. It is decoded from registers only, with no `pulse_in` path.

## Timing
- Reset values:
  - State IDLE.
  - `locked`, `predict`, `err_pulse` = 0.
  - `period` = 0.
- Reset asserted mid-operation returns all state to these values immediately, independent of `clk`.
- `event` is combinational in the cycle of the edge. All state changes occur at the clock edge that ends that cycle.
- `locked` and `period` update one cycle after the qualifying event cycle.
- `err_pulse` is registered. It is high for exactly the one cycle after the error is detected.
- Lock latency: LOCK_COUNT+1 strobe edges. `locked` rises the cycle after the (LOCK_COUNT+1)-th edge.
- Multi-cycle-high `pulse_in` counts as one event. Period 1 (constant high) never produces a second event.

## Configuration
- Macro `PULSE_SYNC_MONITOR_STATS_EN`:
  - Defined: adds output `err_count[15:0]`. It increments in the same cycle `err_pulse` is high, saturates at 0xFFFF, and is cleared only by `reset` (reset value 0).
  - Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Package `pulse_sync_monitor_pkg`:
  - State encoding: IDLE = 2'b00, HUNT = 2'b01, VERIFY = 2'b10, LOCKED = 2'b11.
  - `ERR_CNT_W` = 16.
- Sub-module `pulse_edge_detect`: `pulse_d` register plus the `event` output, with async reset.
- Interval counter and FSM live in the top module.

## Test plan
- Strobe period 4, first edge at cycle 2 after reset release (edges at 2, 6, 10, 14) -> `locked` = 1 from cycle 15, `period` = 4, `predict` high at cycles 18, 22, …, `err_pulse` never high.
- Locked at period 4, one strobe omitted -> one `err_pulse` at expected cycle+1, `locked` stays 1. Next on-time strobe clears `miss_cnt`.
- Locked at period 4, two consecutive strobes omitted -> two `err_pulse`, then state IDLE and `locked` = 0. `period` stays 4.
- During VERIFY, intervals 4, 4, 5, 5, 5 -> `period` changes to 5 and `locked` rises after the third interval of 5.
- Period 6 strobe, `pulse_in` held high 3 cycles per strobe -> locks with `period` = 6, with no double counting.
- `reset` asserted mid-lock -> all outputs 0 immediately. With `PULSE_SYNC_MONITOR_STATS_EN` defined, `err_count` = 0 and it counts exactly the injected errors afterwards.
